// File: rtl/if_id_pkg.sv
// rtl/if_id_pkg.sv - shared defaults for the IF/ID pipeline stage
// Purpose : default widths and the bubble (NOP) instruction value.
// Ports   : none (package).
// Config  : IF_ID_SKID_EN selects the two-entry skid variant of the stage.
package if_id_pkg;

   localparam int          DEF_INSTR_W = 32;
   localparam int          DEF_PC_W    = 32;
   localparam int          DEF_CNT_W   = 16;
   localparam logic [31:0] DEF_NOP     = 32'h0000_0000;

endpackage

// File: rtl/if_id_skid_buf.sv
// rtl/if_id_skid_buf.sv - two-entry skid buffer (main + skid) for the IF/ID stage
// Purpose : holds up to two entries so the upstream ready comes from a register.
// Ports   : clk, rst (sync, active-high), i_flush,
//           i_valid/o_ready/i_data (upstream), o_valid/i_ready/o_data (downstream).
// Config  : instantiated only when IF_ID_SKID_EN is defined.
module if_id_skid_buf
   import if_id_pkg::*;
#(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_flush,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [W-1:0] o_data
);

   logic         r_m_valid;
   logic [W-1:0] r_m_data;
   logic         r_s_valid;
   logic [W-1:0] r_s_data;
   logic         w_in_xfer;

   // Ready depends only on the skid register, never on i_ready.
   assign o_ready   = !rst && !r_s_valid;
   assign w_in_xfer = i_valid && o_ready;
   assign o_valid   = r_m_valid;
   assign o_data    = r_m_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_m_valid <= 1'b0;
         r_m_data  <= '0;
         r_s_valid <= 1'b0;
         r_s_data  <= '0;
      end else if (i_flush) begin
         r_m_valid <= 1'b0;
         r_s_valid <= 1'b0;
      end else if (r_m_valid && !i_ready) begin
         // Main is blocked: a newly accepted entry parks in the skid.
         if (w_in_xfer) begin
            r_s_valid <= 1'b1;
            r_s_data  <= i_data;
         end
      end else if (r_s_valid) begin
         // Main drains: the older skid entry goes first to keep order.
         // No input can be accepted here because o_ready was low.
         r_m_valid <= 1'b1;
         r_m_data  <= r_s_data;
         r_s_valid <= 1'b0;
      end else if (w_in_xfer) begin
         r_m_valid <= 1'b1;
         r_m_data  <= i_data;
      end else begin
         r_m_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/if_id_pipe_stage.sv
// rtl/if_id_pipe_stage.sv - IF/ID pipeline latch with valid/ready, flush and stall counter
// Purpose : carries instruction + PC+4 from fetch to decode, inserts bubbles on flush.
// Ports   : clk, rst (sync, active-high), flush,
//           in_valid/in_ready/instr_in/pc4_in (from fetch),
//           out_valid/out_ready/instr_out/pc4_out (to decode),
//           stall_cnt (saturating count of out_valid && !out_ready edges).
// Config  : IF_ID_SKID_EN adds a skid entry (registered in_ready, capacity 2);
//           undefined gives a single stage with in_ready combinational on out_ready.
module if_id_pipe_stage
   import if_id_pkg::*;
#(
   parameter int          INSTR_W   = DEF_INSTR_W,
   parameter int          PC_W      = DEF_PC_W,
   parameter int          CNT_W     = DEF_CNT_W,
   parameter logic [31:0] NOP_VALUE = DEF_NOP
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic [PC_W-1:0]    pc4_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] instr_out,
   output logic [PC_W-1:0]    pc4_out,
   output logic [CNT_W-1:0]   stall_cnt
);

   localparam int W = INSTR_W + PC_W;

   logic               w_valid;
   logic [W-1:0]       w_data;
   logic [INSTR_W-1:0] w_nop;
   logic [CNT_W-1:0]   r_stall_cnt;

   assign w_nop = INSTR_W'(NOP_VALUE);

`ifdef IF_ID_SKID_EN
   if_id_skid_buf #(
      .W (W)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_flush (flush),
      .i_valid (in_valid),
      .o_ready (in_ready),
      .i_data  ({instr_in, pc4_in}),
      .o_valid (w_valid),
      .i_ready (out_ready),
      .o_data  (w_data)
   );
`else
   logic         r_valid;
   logic [W-1:0] r_data;

   assign in_ready = !rst && (!r_valid || out_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (in_valid && in_ready) begin
         // Covers the full + consumed case: new entry replaces old, no bubble.
         r_valid <= 1'b1;
         r_data  <= {instr_in, pc4_in};
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign w_valid = r_valid;
   assign w_data  = r_data;
`endif

   // Bubble values are forced at the output so stale payload never leaks.
   assign out_valid = w_valid;
   assign instr_out = w_valid ? w_data[W-1:PC_W] : w_nop;
   assign pc4_out   = w_valid ? w_data[PC_W-1:0] : '0;

   // Flush deliberately does not touch the counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (w_valid && !out_ready && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_if_id_pipe_stage.sv
// tb/tb_if_id_pipe_stage.sv - self-checking bench for if_id_pipe_stage
module tb_if_id_pipe_stage;

`ifdef IF_ID_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   localparam logic [31:0] IA = 32'h2008_0005;
   localparam logic [31:0] IB = 32'h2009_0003;
   localparam logic [31:0] IC = 32'h0109_5020;
   localparam logic [31:0] IJ = 32'h0800_0010;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr_in;
   logic [31:0] pc4_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] instr_out;
   logic [31:0] pc4_out;
   logic [15:0] stall_cnt;

   logic        in_ready4;
   logic        out_valid4;
   logic [31:0] instr_out4;
   logic [31:0] pc4_out4;
   logic [3:0]  stall_cnt4;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   if_id_pipe_stage dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr_in  (instr_in),
      .pc4_in    (pc4_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .instr_out (instr_out),
      .pc4_out   (pc4_out),
      .stall_cnt (stall_cnt)
   );

   if_id_pipe_stage #(.CNT_W(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready4),
      .instr_in  (instr_in),
      .pc4_in    (pc4_in),
      .out_valid (out_valid4),
      .out_ready (out_ready),
      .instr_out (instr_out4),
      .pc4_out   (pc4_out4),
      .stall_cnt (stall_cnt4)
   );

   typedef struct {
      logic        v;
      logic [31:0] ins;
      logic [31:0] pc;
      logic        ordy;
      logic        fl;
      logic        e_ir;
      logic        e_ov;
      logic [31:0] e_ins;
      logic [31:0] e_pc;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mk(logic v, logic [31:0] ins, logic [31:0] pc, logic ordy,
                               logic fl, logic e_ir, logic e_ov, logic [31:0] e_ins,
                               logic [31:0] e_pc, logic [15:0] e_cnt);
      vec_t t;
      t.v = v; t.ins = ins; t.pc = pc; t.ordy = ordy; t.fl = fl;
      t.e_ir = e_ir; t.e_ov = e_ov; t.e_ins = e_ins; t.e_pc = e_pc; t.e_cnt = e_cnt;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl);
      @(negedge clk);
      in_valid  = v;
      instr_in  = ins;
      pc4_in    = pc;
      out_ready = ordy;
      flush     = fl;
   endtask

   task automatic chk_out(input string tag, input logic ov, input logic [31:0] ins,
                          input logic [31:0] pc);
      chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
      chk({tag, ".instr_out"}, instr_out, ins);
      chk({tag, ".pc4_out"}, pc4_out, pc);
   endtask

   initial begin
      // stream of three, then idle
      vecs[0]  = mk(1, IA, 32'h4, 1, 0, 1, 1, IA, 32'h4, 0);
      vecs[1]  = mk(1, IB, 32'h8, 1, 0, 1, 1, IB, 32'h8, 0);
      vecs[2]  = mk(1, IC, 32'hC, 1, 0, 1, 1, IC, 32'hC, 0);
      vecs[3]  = mk(0, 0,  0,     1, 0, 1, 0, 0,  0,     0);
      // load IA, stall five cycles, release
      vecs[4]  = mk(1, IA, 32'h4, 1, 0, 1, 1, IA, 32'h4, 0);
      vecs[5]  = mk(0, 0,  0,     0, 0, SKID, 1, IA, 32'h4, 1);
      vecs[6]  = mk(0, 0,  0,     0, 0, SKID, 1, IA, 32'h4, 2);
      vecs[7]  = mk(0, 0,  0,     0, 0, SKID, 1, IA, 32'h4, 3);
      vecs[8]  = mk(0, 0,  0,     0, 0, SKID, 1, IA, 32'h4, 4);
      vecs[9]  = mk(0, 0,  0,     0, 0, SKID, 1, IA, 32'h4, 5);
      vecs[10] = mk(0, 0,  0,     1, 0, 1, 0, 0,  0,     5);
      // flush while full and stalled, incoming jump target dropped
      vecs[11] = mk(1, IA, 32'h4, 0, 0, 1, 1, IA, 32'h4, 5);
      vecs[12] = mk(1, IJ, 32'h10, 0, 1, SKID, 0, 0, 0, 6);
      vecs[13] = mk(0, 0,  0,     1, 0, 1, 0, 0,  0,     6);
      // flush together with out_ready
      vecs[14] = mk(1, IB, 32'h8, 1, 0, 1, 1, IB, 32'h8, 6);
      vecs[15] = mk(1, IJ, 32'h10, 1, 1, 1, 0, 0, 0, 6);

      rst = 1'b1; flush = 0; in_valid = 0; instr_in = 0; pc4_in = 0; out_ready = 0;
      @(posedge clk); #1;
      chk("rst.in_ready", {31'd0, in_ready}, 32'd0);
      chk_out("rst", 0, 0, 0);
      chk("rst.stall_cnt", {16'd0, stall_cnt}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst.in_ready", {31'd0, in_ready}, 32'd1);

      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].v, vecs[i].ins, vecs[i].pc, vecs[i].ordy, vecs[i].fl);
         #1;
         chk($sformatf("v%0d.in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_ir});
         @(posedge clk); #1;
         chk_out($sformatf("v%0d", i), vecs[i].e_ov, vecs[i].e_ins, vecs[i].e_pc);
         chk($sformatf("v%0d.stall_cnt", i), {16'd0, stall_cnt}, {16'd0, vecs[i].e_cnt});
      end

      // backpressure: ready behaviour with the stage full
      drive(1, IA, 32'h4, 1, 0);
      @(posedge clk);
      drive(1, IB, 32'h8, 0, 0);
      #1;
      chk("bp.in_ready_full", {31'd0, in_ready}, {31'd0, SKID});
      if (!SKID) begin
         out_ready = 1'b1;
         #1;
         chk("bp.in_ready_comb", {31'd0, in_ready}, 32'd1);
         out_ready = 1'b0;
         #1;
         chk("bp.in_ready_back", {31'd0, in_ready}, 32'd0);
      end
      @(posedge clk); #1;
      chk_out("bp.hold", 1, IA, 32'h4);
      chk("bp.in_ready_after", {31'd0, in_ready}, 32'd0);
      drive(1, IC, 32'hC, 0, 0);
      @(posedge clk); #1;
      chk_out("bp.hold2", 1, IA, 32'h4);
      drive(0, 0, 0, 1, 0);
      @(posedge clk); #1;
      if (SKID) chk_out("bp.drain1", 1, IB, 32'h8);
      else      chk_out("bp.drain1", 0, 0, 0);
      @(posedge clk); #1;
      chk_out("bp.drain2", 0, 0, 0);

      // reset in the middle of a stall
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      drive(1, IA, 32'h4, 1, 0);
      @(posedge clk);
      drive(0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("rs.stall3", {16'd0, stall_cnt}, 32'd3);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rs.in_ready_rst", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      chk_out("rs", 0, 0, 0);
      chk("rs.stall_cnt", {16'd0, stall_cnt}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rs.in_ready_after", {31'd0, in_ready}, 32'd1);

      // saturation of the 4-bit counter
      drive(1, IA, 32'h4, 1, 0);
      @(posedge clk);
      drive(0, 0, 0, 0, 0);
      repeat (15) @(posedge clk);
      #1;
      chk("sat.cnt4_15", {28'd0, stall_cnt4}, 32'd15);
      repeat (5) @(posedge clk);
      #1;
      chk("sat.cnt4_20", {28'd0, stall_cnt4}, 32'd15);
      chk("sat.cnt16_20", {16'd0, stall_cnt}, 32'd20);
      chk("sat.ov4", {31'd0, out_valid4}, 32'd1);
      chk("sat.ins4", instr_out4, IA);
      chk("sat.pc4", pc4_out4, 32'h4);
      chk("sat.ir4", {31'd0, in_ready4}, {31'd0, SKID});
      drive(0, 0, 0, 1, 0);
      @(posedge clk); #1;
      chk("sat.release", {31'd0, out_valid4}, 32'd0);
      chk("sat.cnt4_hold", {28'd0, stall_cnt4}, 32'd15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
